// File: rtl/oled_spi_rx.sv
// SSD1306-style SPI responder: oversamples the 4-wire display link, assembles
// MSB-first bytes tagged command/data, decodes the controller command set and
// turns data bytes into framebuffer writes with column auto-increment.
module oled_spi_rx #(
    parameter int COL_BITS  = 7,
    parameter int PAGE_BITS = 2
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CS,
    input  logic                          SCLK,
    input  logic                          SDIN,
    input  logic                          DC,
    input  logic                          RES,
    output logic [7:0]                    RX_BYTE,
    output logic                          RX_DC,
    output logic                          RX_VALID,
    output logic                          FB_WE,
    output logic [PAGE_BITS+COL_BITS-1:0] FB_ADDR,
    output logic [7:0]                    FB_WDATA,
    output logic                          DISP_ON,
    output logic [7:0]                    CONTRAST,
    output logic                          FRAME_ERR
);

    typedef enum logic [1:0] {
        ST_CMD,
        ST_ARG1,
        ST_ARG2
    } dec_state_t;

    localparam logic [COL_BITS-1:0] COL_ONE = {{(COL_BITS-1){1'b0}}, 1'b1};

    logic [2:0] cs_sync;
    logic [2:0] sclk_sync;
    logic [1:0] sdin_sync;
    logic [1:0] dc_sync;
    logic [1:0] res_sync;

    logic [2:0] bit_cnt;
    logic [6:0] shift;

    logic sclk_rise;
    logic cs_rise;
    logic res_low;
    logic edge_ok;
    logic byte_done;
    logic byte_dc;
    logic [7:0] new_byte;

    dec_state_t              state, state_next;
    logic [PAGE_BITS-1:0]    page, page_next;
    logic [COL_BITS-1:0]     column, column_next;
    logic [7:0]              opcode, opcode_next;
    logic                    disp_next;
    logic [7:0]              contrast_next;
    logic                    fb_we_next;

    // Bring the asynchronous link lines into the CLK domain; the idle-high
    // lines reset high so that releasing reset never looks like an edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cs_sync   <= 3'b111;
            sclk_sync <= 3'b111;
            sdin_sync <= 2'b00;
            dc_sync   <= 2'b00;
            res_sync  <= 2'b11;
        end else begin
            cs_sync   <= {cs_sync[1:0], CS};
            sclk_sync <= {sclk_sync[1:0], SCLK};
            sdin_sync <= {sdin_sync[0], SDIN};
            dc_sync   <= {dc_sync[0], DC};
            res_sync  <= {res_sync[0], RES};
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign res_low   = ~res_sync[1];
    // An SCLK edge arriving together with the CS rise still counts, so a byte
    // finishing exactly as CS deasserts is delivered rather than flagged.
    assign edge_ok   = sclk_rise & (~cs_sync[1] | cs_rise);
    assign byte_done = edge_ok & (bit_cnt == 3'd7);
    assign byte_dc   = dc_sync[1];
    assign new_byte  = {shift, sdin_sync[1]};

    // Shift register, bit counter, received-byte outputs and framing error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            RX_BYTE   <= 8'd0;
            RX_DC     <= 1'b0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else if (res_low) begin
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
            RX_BYTE   <= 8'd0;
            RX_DC     <= 1'b0;
            RX_VALID  <= 1'b0;
            FRAME_ERR <= 1'b0;
        end else begin
            RX_VALID  <= byte_done;
            FRAME_ERR <= cs_rise & (bit_cnt != 3'd0) & ~byte_done;
            if (byte_done) begin
                RX_BYTE <= new_byte;
                RX_DC   <= byte_dc;
                bit_cnt <= 3'd0;
                shift   <= 7'd0;
            end else if (cs_sync[1]) begin
                bit_cnt <= 3'd0;
                shift   <= 7'd0;
            end else if (edge_ok) begin
                shift   <= {shift[5:0], sdin_sync[1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // Decoder state register; display reset returns it to command state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_CMD;
        end else if (res_low) begin
            state <= ST_CMD;
        end else begin
            state <= state_next;
        end
    end

    // Decode each completed byte into next-state and register updates.
    always_comb begin
        state_next    = state;
        page_next     = page;
        column_next   = column;
        opcode_next   = opcode;
        disp_next     = DISP_ON;
        contrast_next = CONTRAST;
        fb_we_next    = 1'b0;
        if (byte_done) begin
            if (byte_dc) begin
                fb_we_next  = 1'b1;
                column_next = column + COL_ONE;
            end else begin
                case (state)
                    ST_CMD: begin
                        if (new_byte == 8'hAE) begin
                            disp_next = 1'b0;
                        end else if (new_byte == 8'hAF) begin
                            disp_next = 1'b1;
                        end else if (new_byte[7:4] == 4'h0) begin
                            column_next[3:0] = new_byte[3:0];
                        end else if (new_byte[7:4] == 4'h1) begin
                            column_next[COL_BITS-1:4] = new_byte[COL_BITS-5:0];
                        end else if (new_byte[7:3] == 5'b10110) begin
                            page_next = new_byte[PAGE_BITS-1:0];
                        end else if (new_byte == 8'h81 || new_byte == 8'h8D ||
                                     new_byte == 8'hD5 || new_byte == 8'hA8 ||
                                     new_byte == 8'hD3 || new_byte == 8'hDA ||
                                     new_byte == 8'hD9 || new_byte == 8'hDB ||
                                     new_byte == 8'h20 || new_byte == 8'h21 ||
                                     new_byte == 8'h22) begin
                            state_next  = ST_ARG1;
                            opcode_next = new_byte;
                        end
                    end
                    ST_ARG1: begin
                        if (opcode == 8'h81) begin
                            contrast_next = new_byte;
                        end else if (opcode == 8'h21) begin
                            column_next = new_byte[COL_BITS-1:0];
                        end else if (opcode == 8'h22) begin
                            page_next = new_byte[PAGE_BITS-1:0];
                        end
                        if (opcode == 8'h21 || opcode == 8'h22) begin
                            state_next = ST_ARG2;
                        end else begin
                            state_next = ST_CMD;
                        end
                    end
                    default: begin
                        state_next = ST_CMD;
                    end
                endcase
            end
        end
    end

    // Display state registers and the framebuffer write port.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            page     <= '0;
            column   <= '0;
            opcode   <= 8'd0;
            DISP_ON  <= 1'b0;
            CONTRAST <= 8'h7F;
            FB_WE    <= 1'b0;
            FB_ADDR  <= '0;
            FB_WDATA <= 8'd0;
        end else if (res_low) begin
            page     <= '0;
            column   <= '0;
            opcode   <= 8'd0;
            DISP_ON  <= 1'b0;
            CONTRAST <= 8'h7F;
            FB_WE    <= 1'b0;
            FB_ADDR  <= '0;
            FB_WDATA <= 8'd0;
        end else begin
            page     <= page_next;
            column   <= column_next;
            opcode   <= opcode_next;
            DISP_ON  <= disp_next;
            CONTRAST <= contrast_next;
            FB_WE    <= fb_we_next;
            if (fb_we_next) begin
                FB_ADDR  <= {page, column};
                FB_WDATA <= new_byte;
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
// Bench for oled_spi_rx: a vector table of SPI bytes with expected display
// state, a scoreboard of expected received bytes/framebuffer writes, and
// hand-written reset, abort, CS-edge and RES sequences.
module tb_oled_spi_rx;

    logic       CLK;
    logic       RST_N;
    logic       CS;
    logic       SCLK;
    logic       SDIN;
    logic       DC;
    logic       RES;
    logic [7:0] RX_BYTE;
    logic       RX_DC;
    logic       RX_VALID;
    logic       FB_WE;
    logic [8:0] FB_ADDR;
    logic [7:0] FB_WDATA;
    logic       DISP_ON;
    logic [7:0] CONTRAST;
    logic       FRAME_ERR;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       we;
        logic [8:0] addr;
    } exp_t;

    typedef struct {
        logic       dc;
        logic [7:0] data;
        logic       we;
        logic [8:0] addr;
        logic       disp;
        logic [7:0] contrast;
    } vec_t;

    exp_t sbq[$];
    exp_t monE;
    vec_t vecs[18];

    int checks = 0;
    int errors = 0;
    int frameErrCount = 0;
    int rxCount = 0;
    int frameBefore;
    int rxBefore;
    logic prevValid = 1'b0;

    oled_spi_rx dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .CS(CS),
        .SCLK(SCLK),
        .SDIN(SDIN),
        .DC(DC),
        .RES(RES),
        .RX_BYTE(RX_BYTE),
        .RX_DC(RX_DC),
        .RX_VALID(RX_VALID),
        .FB_WE(FB_WE),
        .FB_ADDR(FB_ADDR),
        .FB_WDATA(FB_WDATA),
        .DISP_ON(DISP_ON),
        .CONTRAST(CONTRAST),
        .FRAME_ERR(FRAME_ERR)
    );

    // System clock, 10 ns period; SPI runs at a quarter of this.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drive nbits of b MSB-first; optionally raise CS with the last rising edge.
    task automatic sendBits(input logic [7:0] b, input logic dcv, input int nbits,
                            input bit raiseCs);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            SDIN = b[7-i];
            DC   = dcv;
            #20;
            SCLK = 1'b1;
            if (raiseCs && i == nbits - 1) CS = 1'b1;
            #20;
        end
    endtask

    task automatic applyStimulus(input logic dcv, input logic [7:0] b, input logic we,
                                 input logic [8:0] addr, input bit raiseCs);
        exp_t e;
        e.dc   = dcv;
        e.data = b;
        e.we   = we;
        e.addr = addr;
        sbq.push_back(e);
        sendBits(b, dcv, 8, raiseCs);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("scoreboard_drain", 16'(sbq.size()), 16'd0);
        sbq.delete();
    endtask

    // Scoreboard monitor: every RX_VALID pops one expected byte and compares.
    always @(negedge CLK) begin
        if (RST_N === 1'b1) begin
            if (FB_WE && !RX_VALID) checkOutput("fb_we_without_rx_valid", 16'd1, 16'd0);
            if (RX_VALID) begin
                rxCount++;
                checkOutput("rx_valid_width", {15'd0, prevValid}, 16'd0);
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rx_byte", {8'd0, RX_BYTE}, 16'hFFFF);
                end else begin
                    monE = sbq.pop_front();
                    checkOutput("rx_byte", {8'd0, RX_BYTE}, {8'd0, monE.data});
                    checkOutput("rx_dc", {15'd0, RX_DC}, {15'd0, monE.dc});
                    checkOutput("fb_we", {15'd0, FB_WE}, {15'd0, monE.we});
                    if (monE.we) begin
                        checkOutput("fb_addr", {7'd0, FB_ADDR}, {7'd0, monE.addr});
                        checkOutput("fb_wdata", {8'd0, FB_WDATA}, {8'd0, monE.data});
                    end
                end
            end
            if (FRAME_ERR) frameErrCount++;
            prevValid = RX_VALID;
        end
    end

    // Main test sequence.
    initial begin
        vecs[0]  = '{1'b0, 8'hAF, 1'b0, 9'h000, 1'b1, 8'h7F};
        vecs[1]  = '{1'b0, 8'hAE, 1'b0, 9'h000, 1'b0, 8'h7F};
        vecs[2]  = '{1'b0, 8'h81, 1'b0, 9'h000, 1'b0, 8'h7F};
        vecs[3]  = '{1'b0, 8'h3C, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[4]  = '{1'b0, 8'h22, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[5]  = '{1'b0, 8'h03, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[6]  = '{1'b0, 8'h00, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[7]  = '{1'b1, 8'h55, 1'b1, 9'h180, 1'b0, 8'h3C};
        vecs[8]  = '{1'b0, 8'hB1, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[9]  = '{1'b0, 8'h0E, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[10] = '{1'b0, 8'h17, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[11] = '{1'b1, 8'hA5, 1'b1, 9'h0FE, 1'b0, 8'h3C};
        vecs[12] = '{1'b1, 8'h5A, 1'b1, 9'h0FF, 1'b0, 8'h3C};
        vecs[13] = '{1'b1, 8'hC3, 1'b1, 9'h080, 1'b0, 8'h3C};
        vecs[14] = '{1'b0, 8'h81, 1'b0, 9'h000, 1'b0, 8'h3C};
        vecs[15] = '{1'b1, 8'h11, 1'b1, 9'h081, 1'b0, 8'h3C};
        vecs[16] = '{1'b0, 8'h20, 1'b0, 9'h000, 1'b0, 8'h20};
        vecs[17] = '{1'b0, 8'hAF, 1'b0, 9'h000, 1'b1, 8'h20};

        RST_N = 1'b0;
        CS    = 1'b1;
        SCLK  = 1'b1;
        SDIN  = 1'b0;
        DC    = 1'b0;
        RES   = 1'b1;
        repeat (3) @(negedge CLK);
        checkOutput("reset_rx_valid", {15'd0, RX_VALID}, 16'd0);
        checkOutput("reset_disp_on", {15'd0, DISP_ON}, 16'd0);
        checkOutput("reset_contrast", {8'd0, CONTRAST}, 16'h007F);
        checkOutput("reset_fb_we", {15'd0, FB_WE}, 16'd0);

        $display("[TB] reset released, mid-byte reset sequence");
        RST_N = 1'b1;
        CS    = 1'b0;
        #40;
        applyStimulus(1'b0, 8'hAF, 1'b0, 9'h000, 1'b0);
        waitDrain();
        checkOutput("pre_reset_disp_on", {15'd0, DISP_ON}, 16'd1);
        sendBits(8'hFF, 1'b0, 5, 1'b0);
        RST_N = 1'b0;
        #30;
        checkOutput("midbyte_reset_disp_on", {15'd0, DISP_ON}, 16'd0);
        checkOutput("midbyte_reset_contrast", {8'd0, CONTRAST}, 16'h007F);
        checkOutput("midbyte_reset_rx_byte", {8'd0, RX_BYTE}, 16'd0);
        checkOutput("midbyte_reset_frame_err", {15'd0, FRAME_ERR}, 16'd0);
        RST_N = 1'b1;
        #40;

        $display("[TB] vector table");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].dc, vecs[i].data, vecs[i].we, vecs[i].addr, 1'b0);
            waitDrain();
            checkOutput("table_disp_on", {15'd0, DISP_ON}, {15'd0, vecs[i].disp});
            checkOutput("table_contrast", {8'd0, CONTRAST}, {8'd0, vecs[i].contrast});
        end
        checkOutput("table_no_frame_err", 16'(frameErrCount), 16'd0);

        $display("[TB] aborted byte");
        frameBefore = frameErrCount;
        rxBefore    = rxCount;
        sendBits(8'hB5, 1'b0, 5, 1'b0);
        CS = 1'b1;
        #200;
        checkOutput("abort_frame_err_pulses", 16'(frameErrCount - frameBefore), 16'd1);
        checkOutput("abort_no_rx_valid", 16'(rxCount - rxBefore), 16'd0);
        CS = 1'b0;
        #40;
        applyStimulus(1'b0, 8'hB2, 1'b0, 9'h000, 1'b0);
        waitDrain();
        applyStimulus(1'b1, 8'h77, 1'b1, 9'h102, 1'b0);
        waitDrain();

        $display("[TB] byte completion coincident with CS rise");
        frameBefore = frameErrCount;
        applyStimulus(1'b0, 8'hE3, 1'b0, 9'h000, 1'b1);
        #100;
        waitDrain();
        checkOutput("cs_edge_no_frame_err", 16'(frameErrCount - frameBefore), 16'd0);
        CS = 1'b0;
        #40;
        applyStimulus(1'b1, 8'h3E, 1'b1, 9'h103, 1'b0);
        waitDrain();

        $display("[TB] display reset pulse");
        applyStimulus(1'b0, 8'hAF, 1'b0, 9'h000, 1'b0);
        waitDrain();
        checkOutput("pre_res_disp_on", {15'd0, DISP_ON}, 16'd1);
        applyStimulus(1'b0, 8'hB3, 1'b0, 9'h000, 1'b0);
        waitDrain();
        RES = 1'b0;
        #100;
        checkOutput("res_disp_on", {15'd0, DISP_ON}, 16'd0);
        checkOutput("res_contrast", {8'd0, CONTRAST}, 16'h007F);
        checkOutput("res_rx_byte", {8'd0, RX_BYTE}, 16'd0);
        checkOutput("res_fb_addr", {7'd0, FB_ADDR}, 16'd0);
        RES = 1'b1;
        #60;
        applyStimulus(1'b1, 8'h99, 1'b1, 9'h000, 1'b0);
        waitDrain();
        checkOutput("final_no_frame_err", 16'(frameErrCount - frameBefore), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
